// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO helpers (clog2, lane order, status-flag struct) for the FIFO family
package fifo_pkg;
    localparam bit LANE_LSB_FIRST = 1'b1;
    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_status_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/fifo_wconv_sc_if.sv
// fifo_wconv_sc_if: producer/consumer bus of the width-upsizing FIFO
//   master: drives pi_data, pi_flag, rdreq (and flush when WCONV_FLUSH_EN), observes status/data
//   slave : the FIFO side, drives po_data, wrusedw, rdusedw and the full/empty/threshold flags
interface fifo_wconv_sc_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 2,
    parameter int DEPTH = 128
);
    import fifo_pkg::*;
    localparam int OUT_W = IN_W * RATIO;
    logic [IN_W-1:0]                 pi_data;
    logic                            pi_flag;
    logic                            rdreq;
`ifdef WCONV_FLUSH_EN
    logic                            flush;
`endif
    logic [OUT_W-1:0]                po_data;
    logic [clog2(DEPTH*RATIO):0]     wrusedw;
    logic [clog2(DEPTH):0]           rdusedw;
    logic                            wrfull, rdfull, wrempty, rdempty, wr_afull, rd_aempty;
    modport master (
        output pi_data, pi_flag, rdreq,
`ifdef WCONV_FLUSH_EN
        output flush,
`endif
        input po_data, wrusedw, rdusedw, wrfull, rdfull, wrempty, rdempty, wr_afull, rd_aempty
    );
    modport slave (
        input pi_data, pi_flag, rdreq,
`ifdef WCONV_FLUSH_EN
        input flush,
`endif
        output po_data, wrusedw, rdusedw, wrfull, rdfull, wrempty, rdempty, wr_afull, rd_aempty
    );
endinterface

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port
//   clk, rst : clock, sync active-high reset (clears the read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i/rdata_o : read port, rdata_o updates one cycle after re_i and holds otherwise
module sdp_ram
    import fifo_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [clog2(D)-1:0]   waddr_i,
    input  logic [W-1:0]          wdata_i,
    input  logic                  re_i,
    input  logic [clog2(D)-1:0]   raddr_i,
    output logic [W-1:0]          rdata_o
);
    logic [W-1:0] mem [D];
    logic [W-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_wconv_sc.sv
// fifo_wconv_sc: single-clock FIFO packing RATIO narrow input words into one wide stored word
//   sys_clk, sys_rst : clock, sync active-high reset (discards contents incl. partial word)
//   bus (slave)      : pi_data/pi_flag write side, rdreq/po_data read side (1-cycle latency),
//                      wrusedw (input-word units), rdusedw (output words), full/empty/threshold flags
//   Optional macro WCONV_FLUSH_EN adds bus.flush to commit a partially packed word zero-filled.
module fifo_wconv_sc
    import fifo_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 128,
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 4
) (
    input logic            sys_clk,
    input logic            sys_rst,
    fifo_wconv_sc_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int AW    = clog2(DEPTH);
    localparam int LW    = clog2(RATIO);
    logic [AW:0]                  stored_q, stored_d;
    logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]                pack_cnt_q, pack_cnt_d, lane;
    logic [RATIO-1:0][IN_W-1:0]   packer_q, packer_d;
    logic                         wr_en, rd_en, commit, flush_ok;
    fifo_status_t                 st;
    assign st.full   = stored_q == (AW+1)'(DEPTH);
    assign st.empty  = stored_q == '0;
    assign st.afull  = stored_q >= (AW+1)'(AFULL_TH);
    assign st.aempty = stored_q <= (AW+1)'(AEMPTY_TH);
    assign wr_en = bus.pi_flag & ~st.full;
    assign rd_en = bus.rdreq & ~st.empty;
`ifdef WCONV_FLUSH_EN
    // A flush only commits if there is something in the packer (already or arriving this cycle)
    assign flush_ok = bus.flush & ~st.full & (wr_en | (pack_cnt_q != '0));
`else
    assign flush_ok = 1'b0;
`endif
    assign lane   = LANE_LSB_FIRST ? pack_cnt_q : LW'(RATIO-1) - pack_cnt_q;
    assign commit = (wr_en & (pack_cnt_q == LW'(RATIO-1))) | flush_ok;
    always_comb begin
        packer_d = packer_q;
        if (wr_en) packer_d[lane] = bus.pi_data;
    end
    assign pack_cnt_d = commit ? '0 : pack_cnt_q + LW'(wr_en);
    assign stored_d   = stored_q + (AW+1)'(commit) - (AW+1)'(rd_en);
    // The packer is cleared on commit so lanes not yet filled always read as zero
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stored_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pack_cnt_q <= '0;
            packer_q   <= '0;
        end else begin
            stored_q   <= stored_d;
            wr_ptr_q   <= wr_ptr_q + AW'(commit);
            rd_ptr_q   <= rd_ptr_q + AW'(rd_en);
            pack_cnt_q <= pack_cnt_d;
            packer_q   <= commit ? '0 : packer_d;
        end
    end
    sdp_ram #(.W(OUT_W), .D(DEPTH)) u_ram (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .we_i    (commit),
        .waddr_i (wr_ptr_q),
        .wdata_i (packer_d),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (bus.po_data)
    );
    assign bus.wrusedw   = {stored_q, pack_cnt_q};
    assign bus.rdusedw   = stored_q;
    assign bus.wrfull    = st.full;
    assign bus.rdfull    = st.full;
    assign bus.wrempty   = st.empty & (pack_cnt_q == '0);
    assign bus.rdempty   = st.empty;
    assign bus.wr_afull  = st.afull;
    assign bus.rd_aempty = st.aempty;
endmodule

// File: tb/tb_fifo_wconv_sc.sv
// tb_fifo_wconv_sc: directed self-checking bench for fifo_wconv_sc
module tb_fifo_wconv_sc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fifo_wconv_sc_if bus ();
    fifo_wconv_sc dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));
    int passed = 0;
    int failed = 0;
    int total  = 0;
    logic [15:0] sb[$];
    logic [7:0]  pend;
    logic [7:0]  d;
    logic        rd_ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            bus.rdreq = 1'b1;
            tick();
            chk("drain_data", 32'(bus.po_data), 32'(sb.pop_front()));
        end
        bus.rdreq = 1'b0;
    endtask

    initial begin
        bus.pi_data = '0;
        bus.pi_flag = 1'b0;
        bus.rdreq   = 1'b0;
`ifdef WCONV_FLUSH_EN
        bus.flush   = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rdempty",   32'(bus.rdempty),   32'd1);
        chk("rst_wrempty",   32'(bus.wrempty),   32'd1);
        chk("rst_rd_aempty", 32'(bus.rd_aempty), 32'd1);
        chk("rst_wrusedw",   32'(bus.wrusedw),   32'd0);
        chk("rst_rdusedw",   32'(bus.rdusedw),   32'd0);
        chk("rst_po_data",   32'(bus.po_data),   32'd0);
        chk("rst_wrfull",    32'(bus.wrfull),    32'd0);
        chk("rst_wr_afull",  32'(bus.wr_afull),  32'd0);

        // pack order
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'h11;
        tick();
        chk("pk_wrusedw1", 32'(bus.wrusedw), 32'd1);
        chk("pk_rdusedw0", 32'(bus.rdusedw), 32'd0);
        bus.pi_data = 8'h22;
        tick();
        bus.pi_flag = 1'b0;
        chk("pk_rdusedw1", 32'(bus.rdusedw), 32'd1);
        chk("pk_wrusedw2", 32'(bus.wrusedw), 32'd2);
        chk("pk_rdempty0", 32'(bus.rdempty), 32'd0);
        bus.rdreq = 1'b1;
        tick();
        bus.rdreq = 1'b0;
        chk("pk_data",     32'(bus.po_data), 32'h2211);
        chk("pk_rdusedw",  32'(bus.rdusedw), 32'd0);
        chk("pk_rdempty1", 32'(bus.rdempty), 32'd1);

        // fill to full, overflow drop, drain sequentially
        for (int i = 0; i < 256; i++) begin
            bus.pi_flag = 1'b1;
            bus.pi_data = 8'(i);
            tick();
        end
        bus.pi_flag = 1'b0;
        chk("full_wrfull",  32'(bus.wrfull),   32'd1);
        chk("full_rdfull",  32'(bus.rdfull),   32'd1);
        chk("full_wrusedw", 32'(bus.wrusedw),  32'd256);
        chk("full_rdusedw", 32'(bus.rdusedw),  32'd128);
        chk("full_afull",   32'(bus.wr_afull), 32'd1);
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'h55;
        tick();
        bus.pi_flag = 1'b0;
        chk("drop_wrusedw", 32'(bus.wrusedw), 32'd256);
        for (int k = 0; k < 128; k++) begin
            bus.rdreq = 1'b1;
            tick();
            chk("full_rd_data", 32'(bus.po_data), 32'({8'(2*k+1), 8'(2*k)}));
        end
        chk("full_last",    32'(bus.po_data), 32'hFFFE);
        chk("full_rdempty", 32'(bus.rdempty), 32'd1);
        tick();
        bus.rdreq = 1'b0;
        chk("empty_hold",    32'(bus.po_data), 32'hFFFE);
        chk("drop_no_pack",  32'(bus.wrusedw), 32'd0);

        // thresholds
        for (int i = 0; i < 240; i++) begin
            d = 8'(i) ^ 8'hC3;
            bus.pi_flag = 1'b1;
            bus.pi_data = d;
            tick();
            if (i[0]) sb.push_back({d, pend});
            else pend = d;
            if (i == 237) chk("afull_119", 32'(bus.wr_afull), 32'd0);
            if (i == 239) chk("afull_120", 32'(bus.wr_afull), 32'd1);
        end
        bus.pi_flag = 1'b0;
        while (sb.size() > 4) begin
            bus.rdreq = 1'b1;
            tick();
            chk("th_data", 32'(bus.po_data), 32'(sb.pop_front()));
            if (sb.size() == 5) chk("aempty_5", 32'(bus.rd_aempty), 32'd0);
            if (sb.size() == 4) chk("aempty_4", 32'(bus.rd_aempty), 32'd1);
        end
        bus.rdreq = 1'b0;
        drain();

        // continuous traffic across pointer wrap
        for (int c = 0; c < 1000; c++) begin
            d = 8'(c * 7 + 3);
            bus.pi_flag = 1'b1;
            bus.pi_data = d;
            rd_ok = c[0] && (sb.size() > 0);
            bus.rdreq = c[0];
            tick();
            if (rd_ok) chk("wrap_data", 32'(bus.po_data), 32'(sb.pop_front()));
            if (c[0]) sb.push_back({d, pend});
            else pend = d;
        end
        bus.pi_flag = 1'b0;
        bus.rdreq   = 1'b0;
        tick();
        chk("wrap_rdusedw", 32'(bus.rdusedw), 32'(sb.size()));
        drain();

        // reset mid-fill discards the partial word
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'h77;
        tick();
        bus.pi_flag = 1'b0;
        chk("mid_wrusedw1", 32'(bus.wrusedw), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_wrusedw0", 32'(bus.wrusedw), 32'd0);
        chk("mid_wrempty",  32'(bus.wrempty), 32'd1);
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'h01;
        tick();
        bus.pi_data = 8'h02;
        tick();
        bus.pi_flag = 1'b0;
        bus.rdreq   = 1'b1;
        tick();
        bus.rdreq   = 1'b0;
        chk("mid_repack", 32'(bus.po_data), 32'h0201);

`ifdef WCONV_FLUSH_EN
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'hAB;
        tick();
        bus.pi_flag = 1'b0;
        bus.flush   = 1'b1;
        tick();
        bus.flush   = 1'b0;
        chk("fl_rdusedw", 32'(bus.rdusedw), 32'd1);
        chk("fl_wrusedw", 32'(bus.wrusedw), 32'd2);
        bus.rdreq = 1'b1;
        tick();
        bus.rdreq = 1'b0;
        chk("fl_data", 32'(bus.po_data), 32'h00AB);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_noop", 32'(bus.wrusedw), 32'd0);
        bus.pi_flag = 1'b1;
        bus.pi_data = 8'hCD;
        bus.flush   = 1'b1;
        tick();
        bus.pi_flag = 1'b0;
        bus.flush   = 1'b0;
        chk("fl_wr_rdusedw", 32'(bus.rdusedw), 32'd1);
        bus.rdreq = 1'b1;
        tick();
        bus.rdreq = 1'b0;
        chk("fl_wr_data", 32'(bus.po_data), 32'h00CD);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
